cdc_clear_responder: RTL and testbench
======================================

CDC_CLEAR_RESPONDER -- requirements
Module: cdc_clear_responder

Interface
REQ-001 SHALL have parameter CLEAR_CYCLES, default 4, range 1..255: number of cycles clear_o is held high per CLEAR phase.
REQ-002 SHALL have port clk_i, input, 1: single clock; all logic on rising edge.
REQ-003 SHALL have port rst_i, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port phase_valid_i, input, 1: requested phase is valid.
REQ-005 SHALL have port phase_i, input, 2: requested phase, type cdc_reset_ctrlr_pkg::clear_seq_phase_e.
REQ-006 SHALL have port phase_ready_o, output, 1: responder accepts a phase request.
REQ-007 SHALL have port ack_valid_o, output, 1: phase completion acknowledge valid.
REQ-008 SHALL have port ack_phase_o, output, 2: phase being acknowledged, clear_seq_phase_e.
REQ-009 SHALL have port ack_ready_i, input, 1: initiator side consumes the acknowledge.
REQ-010 SHALL have port isolate_o, output, 1: request local-domain isolation (stop new transactions).
REQ-011 SHALL have port isolate_ack_i, input, 1: local domain reports isolation in effect / released.
REQ-012 SHALL have port clear_o, output, 1: local-domain clear strobe.
REQ-013 SHALL have port cur_phase_o, output, 2: last accepted phase, clear_seq_phase_e.
REQ-014 SHALL have port seq_err_o, output, 1: one-cycle pulse on out-of-order phase acceptance.

Function
REQ-015 SHALL implement FSM states WAIT_REQ, ISO_WAIT, CLR_CNT, REL_WAIT, SEND_ACK.
REQ-016 SHALL drive phase_ready_o=1 only in WAIT_REQ; a request is accepted in cycle N when phase_valid_i & phase_ready_o.
REQ-017 SHALL hold phase_i stable-independent: phase is registered at acceptance; later changes of phase_i have no effect until next acceptance.
REQ-018 SHALL update cur_phase_o in cycle N+1 to the accepted phase.
REQ-019 SHALL treat legal order as IDLE->ISOLATE->CLEAR->POST_CLEAR->IDLE (cyclic).
REQ-020 SHALL, on accepted phase equal to cur_phase_o, perform no action and go directly to SEND_ACK (ack_valid_o=1 from N+1).
REQ-021 SHALL, on accepted phase neither equal to nor the legal successor of cur_phase_o, pulse seq_err_o in cycle N+1 and still execute that phase's action.
REQ-022 ISOLATE: isolate_o=1 from N+1; FSM in ISO_WAIT until isolate_ack_i sampled 1 in cycle M; ack_valid_o=1 from M+1.
REQ-023 CLEAR: isolate_o forced/kept 1; clear_o=1 exactly in cycles N+1..N+CLEAR_CYCLES (CLR_CNT); ack_valid_o=1 from N+CLEAR_CYCLES+1.
REQ-024 CLEAR counter SHALL be $clog2(CLEAR_CYCLES+1) bits, loaded at acceptance, decrementing to zero without wrap.
REQ-025 POST_CLEAR: clear_o=0, isolate_o stays 1; ack_valid_o=1 from N+1.
REQ-026 IDLE: isolate_o=0 from N+1; FSM in REL_WAIT until isolate_ack_i sampled 0 in cycle M; ack_valid_o=1 from M+1.
REQ-027 SHALL, in SEND_ACK, hold ack_valid_o=1 and ack_phase_o=accepted phase stable until ack_ready_i=1; on that handshake cycle K, return to WAIT_REQ with phase_ready_o=1 from K+1.
REQ-028 SHALL never assert ack_valid_o and phase_ready_o in the same cycle (no new request while an ack is pending).
REQ-029 SHALL keep clear_o=0 in every state except CLR_CNT.
REQ-030 SHALL ignore isolate_ack_i outside ISO_WAIT and REL_WAIT; no timeout is applied in wait states.

Reset
REQ-031 SHALL, while rst_i=1, force state WAIT_REQ, cur_phase_o=IDLE, isolate_o=0, clear_o=0, ack_valid_o=0, ack_phase_o=IDLE, seq_err_o=0, counter=0, phase_ready_o=0.
REQ-032 SHALL drive phase_ready_o=1 from the first clock edge after rst_i deasserts.
REQ-033 SHALL abandon any in-progress phase on reset assertion mid-operation (including mid-CLEAR: clear_o drops asynchronously), with no acknowledge emitted afterwards.

Verification
REQ-034 Full legal sequence, CLEAR_CYCLES=4, isolate_ack_i follows isolate_o after 3 cycles, ack_ready_i=1 -> four acks IDLE-order ISOLATE,CLEAR,POST_CLEAR,IDLE; clear_o high exactly 4 cycles; seq_err_o never pulses.
REQ-035 Accept CLEAR at cycle 10 from ISOLATE state, CLEAR_CYCLES=1 -> clear_o high only cycle 11, ack_valid_o from cycle 12, ack_phase_o=CLEAR.
REQ-036 From IDLE request CLEAR -> seq_err_o pulses in N+1, isolate_o=1, clear_o pulses CLEAR_CYCLES cycles, ack issued.
REQ-037 Repeat ISOLATE while cur_phase_o=ISOLATE -> ack_valid_o at N+1, no change on isolate_o/clear_o, no seq_err_o.
REQ-038 ack_ready_i held 0 for 20 cycles after ack -> ack_valid_o/ack_phase_o stable, phase_ready_o=0 throughout; phase_ready_o=1 cycle after ack_ready_i=1.
REQ-039 rst_i asserted in 2nd cycle of CLEAR -> clear_o and isolate_o 0 immediately, cur_phase_o=IDLE, no ack after release, phase_ready_o=1 one edge after release.

Source files
------------

// File: rtl/cdc_reset_ctrlr_pkg.sv
// Shared types for the clear-sequence controller and its responders.
// clear_seq_phase_e encodes the cyclic clear sequence so that the legal
// successor of any phase is simply phase + 1 (mod 4).
package cdc_reset_ctrlr_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISOLATE    = 2'd1,
    CLEAR      = 2'd2,
    POST_CLEAR = 2'd3
  } clear_seq_phase_e;

endpackage

// File: rtl/cdc_clear_responder.sv
// cdc_clear_responder
// Local-domain side of the clear sequence. Accepts one phase request at a
// time, performs the phase action on the local domain (isolation request,
// timed clear strobe, isolation release) and returns an acknowledge that
// must be consumed before the next request is accepted.
//
// Ports
//   clk_i          : clock, all logic on rising edge
//   rst_i          : asynchronous active-high reset
//   phase_valid_i  : phase request valid
//   phase_i        : requested phase
//   phase_ready_o  : request can be accepted (only while waiting for one)
//   ack_valid_o    : phase completion acknowledge valid
//   ack_phase_o    : phase being acknowledged
//   ack_ready_i    : acknowledge consumed
//   isolate_o      : ask the local domain to stop new transactions
//   isolate_ack_i  : local domain reports isolation in effect / released
//   clear_o        : local-domain clear strobe, CLEAR_CYCLES cycles long
//   cur_phase_o    : last accepted phase
//   seq_err_o      : one-cycle pulse when an out-of-order phase is accepted
module cdc_clear_responder
  import cdc_reset_ctrlr_pkg::*;
#(
  parameter int unsigned CLEAR_CYCLES = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             phase_valid_i,
  input  clear_seq_phase_e phase_i,
  output logic             phase_ready_o,
  output logic             ack_valid_o,
  output clear_seq_phase_e ack_phase_o,
  input  logic             ack_ready_i,
  output logic             isolate_o,
  input  logic             isolate_ack_i,
  output logic             clear_o,
  output clear_seq_phase_e cur_phase_o,
  output logic             seq_err_o
);

  localparam int CNT_W = $clog2(CLEAR_CYCLES + 1);

  typedef enum logic [2:0] {
    WAIT_REQ,
    ISO_WAIT,
    CLR_CNT,
    REL_WAIT,
    SEND_ACK
  } state_e;

  state_e           state_q, state_d;
  clear_seq_phase_e phase_q, phase_d;
  logic             isolate_q, isolate_d;
  logic             seq_err_q, seq_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Low while in reset and until the first edge afterwards, so that the
  // reset state (WAIT_REQ) does not advertise readiness during reset.
  logic             live_q;

  logic             accept;
  clear_seq_phase_e succ_phase;

  assign phase_ready_o = live_q && (state_q == WAIT_REQ);
  assign accept        = phase_valid_i && phase_ready_o;
  assign succ_phase    = clear_seq_phase_e'(phase_q + 2'd1);

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    isolate_d = isolate_q;
    seq_err_d = 1'b0;
    cnt_d     = cnt_q;
    case (state_q)
      WAIT_REQ: begin
        if (accept) begin
          phase_d = phase_i;
          if (phase_i == phase_q) begin
            // Repeat of the current phase: nothing to do, just acknowledge.
            state_d = SEND_ACK;
          end else begin
            // Out-of-order phases are flagged but still executed.
            seq_err_d = (phase_i != succ_phase);
            case (phase_i)
              ISOLATE: begin
                isolate_d = 1'b1;
                state_d   = ISO_WAIT;
              end
              CLEAR: begin
                isolate_d = 1'b1;
                cnt_d     = CNT_W'(CLEAR_CYCLES);
                state_d   = CLR_CNT;
              end
              POST_CLEAR: begin
                isolate_d = 1'b1;
                state_d   = SEND_ACK;
              end
              default: begin
                isolate_d = 1'b0;
                state_d   = REL_WAIT;
              end
            endcase
          end
        end
      end
      ISO_WAIT: begin
        if (isolate_ack_i) state_d = SEND_ACK;
      end
      CLR_CNT: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        // Leave on the last strobe cycle; the zero check is a safety exit.
        if (cnt_q <= CNT_W'(1)) state_d = SEND_ACK;
      end
      REL_WAIT: begin
        if (!isolate_ack_i) state_d = SEND_ACK;
      end
      SEND_ACK: begin
        if (ack_ready_i) state_d = WAIT_REQ;
      end
      default: begin
        state_d = WAIT_REQ;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= WAIT_REQ;
      phase_q   <= IDLE;
      isolate_q <= 1'b0;
      seq_err_q <= 1'b0;
      cnt_q     <= '0;
      live_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      isolate_q <= isolate_d;
      seq_err_q <= seq_err_d;
      cnt_q     <= cnt_d;
      live_q    <= 1'b1;
    end
  end

  // Strobe is decoded from the state so it falls with the async reset.
  assign clear_o     = (state_q == CLR_CNT);
  assign ack_valid_o = (state_q == SEND_ACK);
  assign ack_phase_o = phase_q;
  assign cur_phase_o = phase_q;
  assign isolate_o   = isolate_q;
  assign seq_err_o   = seq_err_q;

endmodule

// File: tb/tb_cdc_clear_responder.sv
// Testbench for cdc_clear_responder. Stimulus pushes the expected acknowledge
// (phase and first cycle of ack_valid_o) into a queue; a monitor pops and
// compares whenever the DUT raises an acknowledge.
module tb_cdc_clear_responder;
  import cdc_reset_ctrlr_pkg::*;

  localparam int CC = 4;

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic             phase_valid_i = 1'b0;
  clear_seq_phase_e phase_i = IDLE;
  logic             phase_ready_o;
  logic             ack_valid_o;
  clear_seq_phase_e ack_phase_o;
  logic             ack_ready_i = 1'b1;
  logic             isolate_o;
  logic             isolate_ack_i;
  logic             clear_o;
  clear_seq_phase_e cur_phase_o;
  logic             seq_err_o;

  cdc_clear_responder #(.CLEAR_CYCLES(CC)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .phase_valid_i (phase_valid_i),
    .phase_i       (phase_i),
    .phase_ready_o (phase_ready_o),
    .ack_valid_o   (ack_valid_o),
    .ack_phase_o   (ack_phase_o),
    .ack_ready_i   (ack_ready_i),
    .isolate_o     (isolate_o),
    .isolate_ack_i (isolate_ack_i),
    .clear_o       (clear_o),
    .cur_phase_o   (cur_phase_o),
    .seq_err_o     (seq_err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Local domain model: isolate_ack_i follows isolate_o three cycles later.
  logic [2:0] iso_dly = '0;
  always @(posedge clk) iso_dly <= {iso_dly[1:0], isolate_o};
  assign isolate_ack_i = iso_dly[2];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    clear_seq_phase_e ph;
    int               cyc;
  } exp_t;
  exp_t exp_q[$];

  // Clear strobe monitor: length and first cycle of the latest pulse train.
  int clr_cnt   = 0;
  int clr_first = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (clear_o) begin
        if (clr_cnt == 0) clr_first = cyc;
        clr_cnt++;
      end
    end
  end

  // Acknowledge monitor / scoreboard.
  exp_t mon_e;
  bit   mon_seen = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_i) begin
        mon_seen = 1'b0;
      end else if (ack_valid_o) begin
        chk("ready_with_ack", phase_ready_o, 0);
        if (!mon_seen) begin
          chk("ack_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("ack_phase", ack_phase_o, mon_e.ph);
            chk("ack_cycle", cyc, mon_e.cyc);
          end else begin
            mon_e.ph  = ack_phase_o;
            mon_e.cyc = cyc;
          end
          $display("ack phase=%0d cycle=%0d", ack_phase_o, cyc);
          mon_seen = 1'b1;
        end else begin
          chk("ack_stable", ack_phase_o, mon_e.ph);
        end
        if (ack_ready_i) mon_seen = 1'b0;
      end
    end
  end

  // Issue one request; returns at the cycle after N+1 (N = acceptance cycle).
  task automatic issue(input clear_seq_phase_e p, input int lat, input logic err,
                       output int n);
    bit got = 1'b0;
    n = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk); #1;
      if (phase_ready_o) got = 1'b1;
    end
    chk("ready_wait", int'(got), 1);
    if (!got) return;
    clr_cnt       = 0;
    phase_valid_i = 1'b1;
    phase_i       = p;
    n             = cyc;
    exp_q.push_back('{p, cyc + lat});
    @(posedge clk); #1;
    phase_valid_i = 1'b0;
    phase_i       = clear_seq_phase_e'(~p);
    chk("cur_phase_n1", cur_phase_o, p);
    chk("seq_err_n1", seq_err_o, err);
    @(posedge clk); #1;
    chk("seq_err_n2", seq_err_o, 0);
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (exp_q.size() == 0 && phase_ready_o) ok = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("ack_done", int'(ok), 1);
  endtask

  task automatic do_phase(input clear_seq_phase_e p, input int lat, input logic err,
                          input int clr);
    int n;
    issue(p, lat, err, n);
    wait_done();
    chk("clear_cycles", clr_cnt, clr);
    if (clr > 0) chk("clear_first", clr_first, n + 1);
  endtask

  initial begin
    int  n;
    bit  got;
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit got;
    // Reset state.
    @(posedge clk); #1;
    chk("rst_ready", phase_ready_o, 0);
    chk("rst_ack_valid", ack_valid_o, 0);
    chk("rst_clear", clear_o, 0);
    chk("rst_isolate", isolate_o, 0);
    chk("rst_cur_phase", cur_phase_o, IDLE);
    chk("rst_ack_phase", ack_phase_o, IDLE);
    chk("rst_seq_err", seq_err_o, 0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    chk("rst_ready_release", phase_ready_o, 0);
    @(posedge clk); #1;
    chk("ready_after_release", phase_ready_o, 1);

    // Full legal sequence.
    do_phase(ISOLATE, 5, 1'b0, 0);
    chk("iso_after_isolate", isolate_o, 1);
    do_phase(CLEAR, CC + 1, 1'b0, CC);
    chk("iso_after_clear", isolate_o, 1);
    do_phase(POST_CLEAR, 1, 1'b0, 0);
    chk("iso_after_post", isolate_o, 1);
    do_phase(IDLE, 5, 1'b0, 0);
    chk("iso_after_idle", isolate_o, 0);

    // Repeats of the current phase.
    do_phase(IDLE, 1, 1'b0, 0);
    chk("iso_repeat_idle", isolate_o, 0);
    do_phase(ISOLATE, 5, 1'b0, 0);
    do_phase(ISOLATE, 1, 1'b0, 0);
    chk("iso_repeat_isolate", isolate_o, 1);

    // Acknowledge back-pressure during a CLEAR.
    ack_ready_i = 1'b0;
    issue(CLEAR, CC + 1, 1'b0, n);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      if (ack_valid_o) got = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("hold_ack_seen", int'(got), 1);
    repeat (20) @(posedge clk);
    #1;
    chk("hold_ack_valid", ack_valid_o, 1);
    chk("hold_ready", phase_ready_o, 0);
    chk("hold_ack_phase", ack_phase_o, CLEAR);
    ack_ready_i = 1'b1;
    @(posedge clk); #1;
    chk("hold_released_valid", ack_valid_o, 0);
    chk("hold_released_ready", phase_ready_o, 1);
    chk("hold_clear_cycles", clr_cnt, CC);
    chk("hold_clear_first", clr_first, n + 1);

    // Out-of-order requests.
    do_phase(POST_CLEAR, 1, 1'b0, 0);
    do_phase(ISOLATE, 2, 1'b1, 0);
    do_phase(IDLE, 5, 1'b1, 0);
    chk("iso_after_bad_idle", isolate_o, 0);
    do_phase(CLEAR, CC + 1, 1'b1, CC);
    chk("iso_after_bad_clear", isolate_o, 1);

    // Back to ISOLATE, then reset in the second CLEAR cycle.
    do_phase(POST_CLEAR, 1, 1'b0, 0);
    do_phase(IDLE, 5, 1'b0, 0);
    do_phase(ISOLATE, 5, 1'b0, 0);
    issue(CLEAR, CC + 1, 1'b0, n);
    chk("clear_before_rst", clear_o, 1);
    rst_i = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_clear", clear_o, 0);
    chk("midrst_isolate", isolate_o, 0);
    chk("midrst_cur_phase", cur_phase_o, IDLE);
    chk("midrst_ack_valid", ack_valid_o, 0);
    chk("midrst_ready", phase_ready_o, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    chk("midrst_ready_release", phase_ready_o, 0);
    @(posedge clk); #1;
    chk("midrst_ready_edge", phase_ready_o, 1);
    repeat (20) @(posedge clk);
    #1;
    chk("midrst_no_ack", ack_valid_o, 0);
    chk("midrst_ready_idle", phase_ready_o, 1);

    // Normal operation after reset.
    do_phase(ISOLATE, 5, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
